// File: rtl/read_pkg.sv
// rtl/read_pkg.sv - shared types and default sizes for the register-file read controller
//
// Purpose: holds the controller state enum and the default register width /
// address width used by read_operation and read_mux.
// Ports: none (package).

package read_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

endpackage

// File: rtl/read_mux.sv
// rtl/read_mux.sv - combinational N:1 word selector over the flattened register file
//
// Purpose: returns entry[sel] from the flattened register-file contents.
// Ports:
//   rDataAll  in   DATA_W*N  entry i at bits [i*DATA_W +: DATA_W]
//   sel       in   ADDR_W    entry index
//   sel_data  out  DATA_W    selected entry

module read_mux
  import read_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [DATA_W*(2**ADDR_W)-1:0] rDataAll,
  input  logic [ADDR_W-1:0]             sel,
  output logic [DATA_W-1:0]             sel_data
);

  localparam int N = 2**ADDR_W;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == i[ADDR_W-1:0]) begin
        sel_data = rDataAll[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/read_operation.sv
// rtl/read_operation.sv - register-file read controller with single-read and dump modes
//
// Purpose: presents one register-file entry at a time on a registered
// valid/ready output slot, either on a single read request or as a
// sequential dump of entries 0..N-1 that honours consumer backpressure.
// Ports:
//   clk       in   1          clock, rising edge
//   reset     in   1          asynchronous active-high reset
//   re        in   1          single-read request
//   Addr      in   ADDR_W     single-read address
//   dump      in   1          start a dump of all entries
//   rDataAll  in   DATA_W*N   flattened register-file contents
//   rReady    in   1          consumer ready
//   rData     out  DATA_W     read data
//   rAddr     out  ADDR_W     address of rData
//   rValid    out  1          rData/rAddr valid
//   busy      out  1          dump in progress

module read_operation
  import read_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             Addr,
  input  logic                          dump,
  input  logic [DATA_W*(2**ADDR_W)-1:0] rDataAll,
  input  logic                          rReady,
  output logic [DATA_W-1:0]             rData,
  output logic [ADDR_W-1:0]             rAddr,
  output logic                          rValid,
  output logic                          busy
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic              r_busy;

  logic              w_slot_free;
  logic [ADDR_W-1:0] w_sel;
  logic [DATA_W-1:0] w_sel_data;

  // Slot can take a new word if empty or being drained this cycle.
  assign w_slot_free = !r_valid || rReady;
  assign w_sel       = (r_state == DUMP) ? r_cnt : Addr;

  read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .rDataAll (rDataAll),
    .sel      (w_sel),
    .sel_data (w_sel_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dump) begin
            // Dump wins; a simultaneous re is dropped. Entry 0 loads next edge.
            r_state <= DUMP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (w_slot_free) r_valid <= 1'b0;
          end else if (re && w_slot_free) begin
            r_data  <= w_sel_data;
            r_addr  <= Addr;
            r_valid <= 1'b1;
          end else if (w_slot_free) begin
            r_valid <= 1'b0;
          end
        end
        DUMP: begin
          if (w_slot_free) begin
            r_data  <= w_sel_data;
            r_addr  <= r_cnt;
            r_valid <= 1'b1;
            if (r_cnt == LAST) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rData  = r_data;
  assign rAddr  = r_addr;
  assign rValid = r_valid;
  assign busy   = r_busy;

endmodule

// File: tb/tb_read_operation.sv
// tb/tb_read_operation.sv - self-checking bench for read_operation

module tb_read_operation;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          re;
  logic [AW-1:0] Addr;
  logic          dump;
  logic [DW*N-1:0] rDataAll;
  logic          rReady;
  logic [DW-1:0] rData;
  logic [AW-1:0] rAddr;
  logic          rValid;
  logic          busy;

  read_operation #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .re       (re),
    .Addr     (Addr),
    .dump     (dump),
    .rDataAll (rDataAll),
    .rReady   (rReady),
    .rData    (rData),
    .rAddr    (rAddr),
    .rValid   (rValid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an output slot plus a queue of dump addresses still to send.
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  int            m_dq[$];

  // Handshakes observed on the DUT, in order.
  int obs_addr[$];
  int obs_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_addr  = '0;
    m_dq.delete();
  endtask

  task automatic model_load(input int a);
    m_valid = 1'b1;
    m_data  = rDataAll[a*DW +: DW];
    m_addr  = a[AW-1:0];
  endtask

  task automatic model_step();
    bit free;
    free = !m_valid || rReady;
    if (m_dq.size() > 0) begin
      if (free) model_load(m_dq.pop_front());
    end else if (dump) begin
      for (int i = 0; i < N; i++) m_dq.push_back(i);
      if (free) m_valid = 1'b0;
    end else if (re && free) begin
      model_load(int'(Addr));
    end else if (free) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    logic          p_valid, p_ready;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_addr;
    p_valid = rValid;
    p_ready = rReady;
    p_data  = rData;
    p_addr  = rAddr;
    if (rValid && rReady) begin
      obs_addr.push_back(int'(rAddr));
      obs_data.push_back(int'(rData));
    end
    @(posedge clk);
    model_step();
    #1;
    chk("rValid", rValid, m_valid);
    chk("busy", busy, m_dq.size() != 0);
    if (m_valid) begin
      chk("rData", rData, m_data);
      chk("rAddr", rAddr, m_addr);
    end
    if (p_valid && !p_ready) begin
      chk("stall_data_held", rData, p_data);
      chk("stall_addr_held", rAddr, p_addr);
    end
  endtask

  task automatic fill_default();
    for (int i = 0; i < N; i++) rDataAll[i*DW +: DW] = 8'h10 + i[7:0];
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic check_dump_seq(input string tag);
    chk({tag, "_count"}, obs_addr.size(), 8);
    for (int i = 0; i < N && i < obs_addr.size(); i++) begin
      chk({tag, "_addr"}, obs_addr[i], i);
      chk({tag, "_data"}, obs_data[i], 32'h10 + i);
    end
  endtask

  initial begin
    int busy_cnt;
    int bound;

    reset  = 1'b1;
    re     = 1'b0;
    Addr   = '0;
    dump   = 1'b0;
    rReady = 1'b0;
    fill_default();
    model_reset();
    #1;
    chk("reset_rData", rData, 0);
    chk("reset_rAddr", rAddr, 0);
    chk("reset_rValid", rValid, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single read of entry 3.
    re = 1'b1; Addr = 3'd3; rReady = 1'b1;
    tick();
    chk("single_valid", rValid, 1);
    chk("single_data", rData, 8'h13);
    chk("single_addr", rAddr, 3);
    re = 1'b0;
    tick();
    chk("single_clear", rValid, 0);

    // Backpressure: second request while slot is full is dropped.
    clear_obs();
    rReady = 1'b0;
    re = 1'b1; Addr = 3'd5;
    tick();
    Addr = 3'd6;
    tick();
    chk("bp_data", rData, 8'h15);
    chk("bp_addr", rAddr, 5);
    re = 1'b0;
    tick();
    chk("bp_held", rData, 8'h15);
    rReady = 1'b1;
    tick();
    chk("bp_drained", rValid, 0);
    chk("bp_hs_count", obs_addr.size(), 1);
    if (obs_addr.size() > 0) chk("bp_hs_addr", obs_addr[0], 5);
    tick();

    // Dump has priority over a same-cycle re.
    clear_obs();
    dump = 1'b1; re = 1'b1; Addr = 3'd2; rReady = 1'b1;
    busy_cnt = 0;
    tick();
    if (busy) busy_cnt++;
    dump = 1'b0; re = 1'b0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("dump_busy_cycles", busy_cnt, 8);
    check_dump_seq("dump");

    // Dump with rReady toggling each cycle.
    clear_obs();
    dump = 1'b1; rReady = 1'b1;
    tick();
    dump = 1'b0;
    for (int c = 0; c < 30; c++) begin
      rReady = ~rReady;
      tick();
    end
    rReady = 1'b1;
    tick();
    tick();
    check_dump_seq("stall");

    // Reset mid-dump right after entry 3 is handed over.
    clear_obs();
    dump = 1'b1; rReady = 1'b1;
    tick();
    dump = 1'b0;
    bound = 0;
    while (obs_addr.size() < 4 && bound < 20) begin
      tick();
      bound++;
    end
    chk("middump_reached_entry3", obs_addr.size() >= 4, 1);
    #2 reset = 1'b1;
    #1;
    chk("middump_rData", rData, 0);
    chk("middump_rAddr", rAddr, 0);
    chk("middump_rValid", rValid, 0);
    chk("middump_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    chk("middump_not_resumed", busy, 0);
    re = 1'b1; Addr = 3'd7;
    tick();
    chk("after_reset_data", rData, 8'h17);
    chk("after_reset_valid", rValid, 1);
    re = 1'b0;
    tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++) rDataAll[i*DW +: DW] = DW'($urandom);
      end
      re     = $urandom_range(0, 1) == 1;
      Addr   = AW'($urandom);
      dump   = $urandom_range(0, 15) == 0;
      rReady = $urandom_range(0, 3) != 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/read_operation.md
# read_operation

Read-side controller for the 8-entry register file: the counterpart of the write-enable decoder on the write side. It selects one register from the flattened register-file contents and presents it on a registered output with a valid/ready handshake. It also provides a dump mode that streams all entries in address order, honouring consumer backpressure. It sits between the register array and any consumer, such as a debug port or datapath operand fetch.

## Interface
- DATA_W, default 8: register width in bits.
- ADDR_W, default 3: address width; number of entries N = 2**ADDR_W.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- re  input  1  single-read request, sampled at the rising edge.
- Addr  input  ADDR_W  register address for a single read.
- dump  input  1  start a sequential read of entries 0..N-1.
- rDataAll  input  DATA_W*N  register contents; entry i occupies bits [i*DATA_W +: DATA_W].
- rReady  input  1  consumer ready to accept the output.
- rData  output  DATA_W  read data.
- rAddr  output  ADDR_W  address of the data on rData.
- rValid  output  1  rData and rAddr are valid.
- busy  output  1  dump in progress.

## Operation
- FSM states:
  - IDLE: dump=1 → DUMP with cnt=0; dump has priority, and re in the same cycle is dropped. Otherwise re=1 with the slot free → load entry[Addr].
  - DUMP: slot free → load entry[cnt] with rAddr=cnt, then cnt+1. After loading entry N-1, return to IDLE with cnt=0. re and dump are ignored in DUMP.
- Output slot:
  - The slot is free when rValid=0, or rValid=1 and rReady=1 (handshake this cycle).
  - A load sets rValid=1 and captures rData/rAddr at that edge; the data is a snapshot and later changes to rDataAll do not affect it.
  - Handshake with no new load → rValid=0.
  - rValid=1 and rReady=0 → rData, rAddr and rValid are held stable.
  - A request (re) arriving while the slot is not free is dropped, not queued.
- busy = (state == DUMP), driven from a register.
- cnt is ADDR_W wide. Wrap-around is not used; termination is on cnt == N-1 at load.
- Reset (asynchronous, any time including mid-dump) forces the following. All outputs return to these values immediately, and the aborted dump is not resumed.
  - state=IDLE, cnt=0
  - rData=0, rAddr=0, rValid=0, busy=0

## Timing
- Single read: re sampled at edge k → rValid=1 after edge k with rData=entry[Addr@k].
  - With rReady=1, rValid drops after edge k+1 unless a new re loads at edge k+1.
- Back-to-back single reads with rReady held at 1 sustain one read per cycle.
- Dump with rReady held at 1:
  - dump sampled at edge k → busy=1 after edge k.
  - Entries 0..N-1 are loaded at edges k+1..k+N.
  - busy=0 after edge k+N; the last rValid clears after edge k+N+1.
- Dump under backpressure: each stall cycle delays every later load by one cycle; no address is skipped or repeated.
- No combinational path from any input to any output.

## Structure
- Package read_pkg holds:
  - state enum (IDLE, DUMP)
  - default DATA_W/ADDR_W localparams
- Sub-module read_mux: combinational N:1 selector, (rDataAll, sel) → DATA_W word. It is used with sel = Addr in IDLE and sel = cnt in DUMP.
- Top-level contents: FSM, cnt register, output slot registers.

## Test plan
For all scenarios, rDataAll holds entry i = 8'h10+i.
- Reset: assert reset asynchronously mid-cycle → rData=0, rAddr=0, rValid=0, busy=0 immediately, with no clock edge needed.
- Single read: re=1, Addr=3, rReady=1 for one cycle → next cycle rValid=1, rData=8'h13, rAddr=3; the following cycle rValid=0.
- Backpressure: rReady=0; re with Addr=5, then re with Addr=6 → rData is held at 8'h15 and the Addr=6 request is dropped. Raise rReady → one handshake, then rValid=0.
- Dump priority: dump=1 and re=1 (Addr=2) in the same cycle, rReady=1 →
  - busy high for 8 cycles
  - rAddr 0..7 and rData 8'h10..8'h17 on 8 consecutive valid cycles
  - the Addr=2 request is never output separately
- Dump, stalled: rReady toggles 1/0 every cycle → exactly 8 handshakes, addresses 0..7 in order, data stable during each stall.
- Reset mid-dump: assert reset after the handshake of entry 3 → all outputs 0. After release, dump has not resumed and busy=0. A subsequent re with Addr=7 returns 8'h17 one cycle later.
